vfifo_stream_arbiter: RTL and testbench
=======================================

// Module: vfifo_stream_arbiter
// PURPOSE
//  Shares the single AXI-stream write port of the DDR3 virtual FIFO between two stream sources.
//  Grants one source at a time, burst by burst, with round-robin priority.
//  Drives tdest with the granted channel number and forces tlast at every BURST_WORDS boundary.
//  Skips any channel whose VFIFO S2MM channel reports full.
//  Sits between the acquisition sources and the axi_ddrvfifo s_axis port.
// PARAMETERS
//  DATA_WIDTH   32   tdata width of sources and master
//  BURST_WORDS  128  max beats per grant (512 B burst / 4 B bus); >=2
//  TIMEOUT      64   idle cycles before an empty grant is dropped; >=1
//  CNT_WIDTH    16   width of per-channel burst counters
// PORTS
//  aclk                     in   1           clock
//  aresetn                  in   1           asynchronous reset, active low
//  enable                   in   1           1 = new grants allowed
//  s0_axis_tvalid           in   1           source 0 valid
//  s0_axis_tready           out  1           source 0 ready
//  s0_axis_tdata            in   DATA_WIDTH  source 0 data
//  s0_axis_tlast            in   1           source 0 packet end
//  s1_axis_*                --   --          same four signals for source 1
//  m_axis_tvalid            out  1           to VFIFO s_axis_tvalid
//  m_axis_tready            in   1           from VFIFO s_axis_tready
//  m_axis_tdata             out  DATA_WIDTH  to VFIFO
//  m_axis_tlast             out  1           to VFIFO; burst/packet end
//  m_axis_tdest             out  1           VFIFO channel = granted source
//  vfifo_s2mm_channel_full  in   2           per-channel full flags from VFIFO
//  grant                    out  2           one-hot current grant, 00 when idle
//  busy                     out  1           1 while in XFER
//  burst_cnt0, burst_cnt1   out  CNT_WIDTH   completed bursts per channel; wraps
// BEHAVIOUR
//  Reset (async, aresetn=0)
//   - Outputs clear immediately: all tready, m_axis_*, grant, busy and counters go to 0.
//   - State = IDLE; rr_last = 1, so channel 0 wins first.
//   - Beat counter and timeout counter = 0.
//   - An in-flight burst is abandoned without tlast.
//  FSM: IDLE -> XFER -> IDLE
//  IDLE
//   - All tready = 0; m_axis_tvalid = 0; m_axis_tdata = 0.
//   - eligible[i] = enable & si_tvalid & ~vfifo_s2mm_channel_full[i].
//   - Both eligible: grant ~rr_last. One eligible: grant it. None: stay in IDLE.
//   - Grant is registered; go to XFER. beat_cnt = 0, tmo = 0.
//  XFER (granted channel g)
//   - Combinational pass-through, zero latency:
//     m_tvalid = sg_tvalid, m_tdata = sg_tdata, sg_tready = m_tready, m_tdest = g.
//   - The non-granted source has tready = 0.
//   - m_tlast = sg_tlast | (beat_cnt == BURST_WORDS-1).
//   - Handshake (m_tvalid & m_tready): beat_cnt++.
//   - Handshake with m_tlast = 1: burst_cnt[g]++ (wraps), rr_last = g, go to IDLE.
//   - Dropping an empty grant: when beat_cnt == 0 and sg_tvalid = 0, tmo++.
//     At tmo == TIMEOUT-1: go to IDLE, rr_last = g, no counter increment.
//   - Once beat_cnt > 0 there is no timeout; the grant is held until tlast.
//  Timing and boundary rules
//   - There is exactly one IDLE cycle between bursts; the arbitration gap is 1 clk.
//   - full[g] rising or enable falling mid-burst does not abort the burst.
//     The burst completes; backpressure comes via m_tready.
//   - A source tlast before the boundary ends the burst early.
//     The next burst restarts beat_cnt at 0.
//   - Source tlast on the boundary beat gives a single tlast; no double count.
//   - beat_cnt width = $clog2(BURST_WORDS).
// TESTING
//  1. Only s0 streams 300 words, m_tready = 1:
//     -> tlast on beats 128, 256 and 300; tdest = 0; burst_cnt0 = 3.
//     -> One idle cycle between bursts.
//  2. Both sources valid continuously:
//     -> grants alternate 0,1,0,1 every 128 beats; tdest follows grant.
//  3. full = 2'b01 with both valid:
//     -> only ch1 is granted.
//     -> Set full[1] mid-burst: that burst still ends at beat 128.
//  4. s1 is granted, then drops tvalid before any beat:
//     -> after 64 clk, return to IDLE; burst_cnt1 unchanged; s0 is granted next.
//  5. Random m_tready and random source stalls:
//     -> per channel, data out equals data in, order preserved.
//     -> No beats lost or duplicated.
//  6. aresetn pulsed low mid-burst:
//     -> outputs clear the same cycle without waiting for aclk.
//     -> After release, ch0 wins first.

Source files
------------

// File: rtl/vfifo_stream_arbiter.sv
// vfifo_stream_arbiter
// Round-robin burst arbiter that shares the DDR3 virtual FIFO s_axis write port
// between two AXI-stream sources. One source is granted per burst. The data path
// is a zero-latency pass-through while a grant is held. tlast is forced at every
// BURST_WORDS boundary, and tdest carries the granted channel number.
module vfifo_stream_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int BURST_WORDS = 128,
   parameter int TIMEOUT     = 64,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  enable,
   input  logic                  s0_axis_tvalid,
   output logic                  s0_axis_tready,
   input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
   input  logic                  s0_axis_tlast,
   input  logic                  s1_axis_tvalid,
   output logic                  s1_axis_tready,
   input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
   input  logic                  s1_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tdest,
   input  logic [1:0]            vfifo_s2mm_channel_full,
   output logic [1:0]            grant,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  burst_cnt0,
   output logic [CNT_WIDTH-1:0]  burst_cnt1
);

   localparam int BEAT_W = $clog2(BURST_WORDS);
   localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_WORDS - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_XFER = 1'b1;

   logic [0:0]            state;
   logic                  gnt_ch;
   logic                  rr_last;
   logic [BEAT_W-1:0]     beat_cnt;
   logic [TMO_W-1:0]      tmo;

   logic [1:0]            eligible;
   logic                  pick;
   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  handshake;

   // Arbitration: a channel is eligible when enabled, valid and its VFIFO channel is not full.
   always_comb begin
      eligible[0] = enable & s0_axis_tvalid & ~vfifo_s2mm_channel_full[0];
      eligible[1] = enable & s1_axis_tvalid & ~vfifo_s2mm_channel_full[1];
      if (&eligible) begin
         pick = ~rr_last;
      end else begin
         pick = eligible[1];
      end
   end

   // Source mux for the granted channel.
   always_comb begin
      sel_valid = gnt_ch ? s1_axis_tvalid : s0_axis_tvalid;
      sel_last  = gnt_ch ? s1_axis_tlast  : s0_axis_tlast;
      sel_data  = gnt_ch ? s1_axis_tdata  : s0_axis_tdata;
   end

   // Output stage: pass-through in XFER, everything quiet in IDLE.
   always_comb begin
      m_axis_tvalid  = 1'b0;
      m_axis_tdata   = '0;
      m_axis_tlast   = 1'b0;
      m_axis_tdest   = 1'b0;
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;
      grant          = 2'b00;
      busy           = 1'b0;
      if (state == ST_XFER) begin
         m_axis_tvalid  = sel_valid;
         m_axis_tdata   = sel_data;
         m_axis_tlast   = sel_last | (beat_cnt == BEAT_LAST);
         m_axis_tdest   = gnt_ch;
         s0_axis_tready = ~gnt_ch & m_axis_tready;
         s1_axis_tready = gnt_ch & m_axis_tready;
         grant          = gnt_ch ? 2'b10 : 2'b01;
         busy           = 1'b1;
      end
   end

   // Accepted beat on the master side.
   always_comb handshake = m_axis_tvalid & m_axis_tready;

   // Grant FSM, beat/timeout counters and per-channel completed-burst counters.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= ST_IDLE;
         gnt_ch     <= 1'b0;
         rr_last    <= 1'b1;
         beat_cnt   <= '0;
         tmo        <= '0;
         burst_cnt0 <= '0;
         burst_cnt1 <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|eligible) begin
                  state    <= ST_XFER;
                  gnt_ch   <= pick;
                  beat_cnt <= '0;
                  tmo      <= '0;
               end
            end
            ST_XFER: begin
               if (handshake) begin
                  if (m_axis_tlast) begin
                     state    <= ST_IDLE;
                     rr_last  <= gnt_ch;
                     beat_cnt <= '0;
                     if (gnt_ch) begin
                        burst_cnt1 <= burst_cnt1 + CNT_WIDTH'(1);
                     end else begin
                        burst_cnt0 <= burst_cnt0 + CNT_WIDTH'(1);
                     end
                  end else begin
                     beat_cnt <= beat_cnt + BEAT_W'(1);
                  end
               end else if ((beat_cnt == '0) && !sel_valid) begin
                  // Only a grant that has not moved any beat may be dropped.
                  if (tmo == TMO_LAST) begin
                     state   <= ST_IDLE;
                     rr_last <= gnt_ch;
                  end else begin
                     tmo <= tmo + TMO_W'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vfifo_stream_arbiter.sv
// tb_vfifo_stream_arbiter
// Bench for the two-source VFIFO stream arbiter. Sources push every word they
// present into a per-channel expected queue. A negedge monitor matches master
// beats against those queues and derives the expected tlast from the burst rules.
module tb_vfifo_stream_arbiter;

   localparam int BW = 128;
   localparam int TO = 64;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } word_t;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b1;
   logic        enable = 1'b0;
   logic        sv[2] = '{1'b0, 1'b0};
   logic [31:0] sd[2] = '{32'h0, 32'h0};
   logic        sl[2] = '{1'b0, 1'b0};
   logic        s0_tready, s1_tready;
   logic        m_tvalid, m_tlast, m_tdest;
   logic        m_tready = 1'b0;
   logic [31:0] m_tdata;
   logic [1:0]  full = 2'b00;
   logic [1:0]  grant;
   logic        busy;
   logic [15:0] burst_cnt0, burst_cnt1;

   // Bench control, written by the main sequence only.
   bit          rdy_mode = 1'b0;
   bit          rdy_fixed = 1'b0;
   int          stall_pct = 0;
   bit          manual[2] = '{1'b0, 1'b0};
   bit          man_v[2] = '{1'b0, 1'b0};
   logic [31:0] man_d[2] = '{32'h0, 32'h0};
   word_t       pend[2][$];
   int          seq_n[2] = '{0, 0};

   // Driver-owned state.
   int          pr[2] = '{0, 0};
   word_t       exp_q[2][$];
   word_t       drv_w;

   // Monitor-owned state.
   logic        acc[2] = '{1'b0, 1'b0};
   int          rd[2] = '{0, 0};
   int          cyc = 0;
   int          beat_m = 0;
   int          bursts_m[2] = '{0, 0};
   int          seq[$];
   int          gaps[$];
   int          last_end = 0;
   int          mch;
   bit          el;
   word_t       mw;

   int          total = 0;
   int          bad = 0;

   vfifo_stream_arbiter #(
      .DATA_WIDTH (32),
      .BURST_WORDS(BW),
      .TIMEOUT    (TO),
      .CNT_WIDTH  (16)
   ) dut (
      .aclk                   (aclk),
      .aresetn                (aresetn),
      .enable                 (enable),
      .s0_axis_tvalid         (sv[0]),
      .s0_axis_tready         (s0_tready),
      .s0_axis_tdata          (sd[0]),
      .s0_axis_tlast          (sl[0]),
      .s1_axis_tvalid         (sv[1]),
      .s1_axis_tready         (s1_tready),
      .s1_axis_tdata          (sd[1]),
      .s1_axis_tlast          (sl[1]),
      .m_axis_tvalid          (m_tvalid),
      .m_axis_tready          (m_tready),
      .m_axis_tdata           (m_tdata),
      .m_axis_tlast           (m_tlast),
      .m_axis_tdest           (m_tdest),
      .vfifo_s2mm_channel_full(full),
      .grant                  (grant),
      .busy                   (busy),
      .burst_cnt0             (burst_cnt0),
      .burst_cnt1             (burst_cnt1)
   );

   initial forever #5 aclk = ~aclk;

   // Source and sink drivers: AXI-legal sources that hold a word until accepted.
   always @(posedge aclk) begin
      #2;
      m_tready = rdy_mode ? ($urandom_range(99) < 60) : rdy_fixed;
      for (int c = 0; c < 2; c++) begin
         if (manual[c]) begin
            sv[c] = man_v[c];
            sd[c] = man_d[c];
            sl[c] = 1'b0;
         end else if (!sv[c] || acc[c]) begin
            sv[c] = 1'b0;
            if (pr[c] < pend[c].size() && $urandom_range(99) >= stall_pct) begin
               drv_w = pend[c][pr[c]];
               pr[c]++;
               sv[c] = 1'b1;
               sd[c] = drv_w.data;
               sl[c] = drv_w.last;
               exp_q[c].push_back(drv_w);
            end
         end
      end
   end

   // Monitor / scoreboard: checks every master beat and the idle-state outputs.
   always @(negedge aclk) begin
      cyc++;
      acc[0] = sv[0] & s0_tready;
      acc[1] = sv[1] & s1_tready;
      if (!aresetn) begin
         beat_m      = 0;
         bursts_m[0] = 0;
         bursts_m[1] = 0;
      end else begin
         if (grant === 2'b00) begin
            total++;
            if (m_tvalid !== 1'b0 || s0_tready !== 1'b0 || s1_tready !== 1'b0 || m_tdata !== 32'h0) begin
               bad++;
               $display("FAIL idle_quiet got tvalid=%b tready=%b%b tdata=%h required all zero",
                        m_tvalid, s1_tready, s0_tready, m_tdata);
            end
         end
         if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            mch = (m_tdest === 1'b1) ? 1 : 0;
            el  = (beat_m == BW - 1);
            total++;
            if (rd[mch] >= exp_q[mch].size()) begin
               bad++;
               $display("FAIL beat_extra ch=%0d got data=%h required no beat", mch, m_tdata);
            end else begin
               mw = exp_q[mch][rd[mch]];
               rd[mch]++;
               el = el || mw.last;
               if (m_tdata !== mw.data || m_tlast !== el) begin
                  bad++;
                  $display("FAIL beat ch=%0d got data=%h last=%b required data=%h last=%b",
                           mch, m_tdata, m_tlast, mw.data, el);
               end
            end
            total++;
            if (grant !== (mch ? 2'b10 : 2'b01) || busy !== 1'b1) begin
               bad++;
               $display("FAIL grant_busy ch=%0d got grant=%b busy=%b required onehot busy=1", mch, grant, busy);
            end
            if (beat_m == 0) gaps.push_back(cyc - last_end);
            if (el) begin
               bursts_m[mch]++;
               seq.push_back(mch);
               beat_m   = 0;
               last_end = cyc;
            end else begin
               beat_m++;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s got=%0h required=%0h", name, got, req);
      end
   endtask

   function automatic bit drained();
      return pr[0] == pend[0].size() && pr[1] == pend[1].size() &&
             rd[0] == exp_q[0].size() && rd[1] == exp_q[1].size();
   endfunction

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while (!drained() && n < budget) begin
         tick(1);
         n++;
      end
      check({name, "_drained"}, 64'(drained()), 64'd1);
      tick(4);
   endtask

   task automatic load(input int c, input int n, input int last_pct, input bit last_end_w);
      word_t w;
      for (int i = 0; i < n; i++) begin
         seq_n[c]++;
         w.data = {(c == 1) ? 8'h1B : 8'h0A, 24'(seq_n[c])};
         w.last = ($urandom_range(99) < last_pct) || (last_end_w && i == n - 1);
         pend[c].push_back(w);
      end
   endtask

   task automatic check_seq(input string name, input int s, input logic [7:0] exp_bits, input int n);
      check({name, "_len"}, 64'(seq.size() - s), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (s + i < seq.size()) check({name, "_ch"}, 64'(seq[s + i]), 64'(exp_bits[i]));
      end
   endtask

   initial begin
      int s, g0, b1, n;
      #1 aresetn = 1'b0;
      #2;
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_mvalid", 64'(m_tvalid), 64'd0);
      check("rst_mlast", 64'(m_tlast), 64'd0);
      check("rst_tready", 64'({s1_tready, s0_tready}), 64'd0);
      check("rst_cnt0", 64'(burst_cnt0), 64'd0);
      check("rst_cnt1", 64'(burst_cnt1), 64'd0);
      tick(2);
      aresetn   = 1'b1;
      enable    = 1'b1;
      rdy_fixed = 1'b1;
      tick(2);

      // 1: s0 alone, 300 words, single idle cycle between bursts.
      s  = seq.size();
      g0 = gaps.size();
      load(0, 300, 0, 1'b1);
      wait_drain("t1", 2000);
      check("t1_cnt0", 64'(burst_cnt0), 64'd3);
      check("t1_cnt1", 64'(burst_cnt1), 64'd0);
      check_seq("t1_seq", s, 8'b000, 3);
      check("t1_gaps", 64'(gaps.size() - g0), 64'd3);
      if (gaps.size() >= g0 + 3) begin
         check("t1_gap2", 64'(gaps[g0 + 1]), 64'd2);
         check("t1_gap3", 64'(gaps[g0 + 2]), 64'd2);
      end

      // 2: both sources streaming; ch0 served last, so ch1 first then alternate.
      s = seq.size();
      load(0, 256, 0, 1'b0);
      load(1, 256, 0, 1'b0);
      wait_drain("t2", 3000);
      check_seq("t2_seq", s, 8'b0101, 4);
      check("t2_cnt0", 64'(burst_cnt0), 64'd5);
      check("t2_cnt1", 64'(burst_cnt1), 64'd2);

      // 3: ch0 full, then ch1 full and enable low mid-burst.
      full = 2'b01;
      s  = seq.size();
      b1 = bursts_m[1];
      load(0, 256, 0, 1'b0);
      load(1, 256, 0, 1'b0);
      n = 0;
      while (beat_m < 50 && n < 1000) begin
         tick(1);
         n++;
      end
      check("t3_mid_reached", 64'(beat_m >= 50), 64'd1);
      check("t3_grant_ch1", 64'(grant), 64'b10);
      full   = 2'b11;
      enable = 1'b0;
      n = 0;
      while (bursts_m[1] != b1 + 1 && n < 1000) begin
         tick(1);
         n++;
      end
      tick(20);
      check("t3_parked_busy", 64'(busy), 64'd0);
      check("t3_parked_grant", 64'(grant), 64'd0);
      check("t3_cnt1_mid", 64'(burst_cnt1), 64'd3);
      check("t3_cnt0_mid", 64'(burst_cnt0), 64'd5);
      full   = 2'b00;
      enable = 1'b1;
      wait_drain("t3", 3000);
      check_seq("t3_seq", s, 8'b0101, 4);
      check("t3_cnt0", 64'(burst_cnt0), 64'd7);
      check("t3_cnt1", 64'(burst_cnt1), 64'd4);

      // 4: s1 granted then withdraws before any beat; timeout, then s0.
      rdy_fixed = 1'b0;
      man_d[1]  = 32'hDEAD_0001;
      man_v[1]  = 1'b1;
      manual[1] = 1'b1;
      tick(1);
      check("t4_grant_s1", 64'(grant), 64'b10);
      man_v[1] = 1'b0;
      load(0, 10, 0, 1'b1);
      tick(63);
      check("t4_held_63", 64'(busy), 64'd1);
      tick(1);
      check("t4_dropped_busy", 64'(busy), 64'd0);
      check("t4_dropped_grant", 64'(grant), 64'd0);
      tick(1);
      check("t4_grant_s0", 64'(grant), 64'b01);
      rdy_fixed = 1'b1;
      manual[1] = 1'b0;
      wait_drain("t4", 1000);
      check("t4_cnt1", 64'(burst_cnt1), 64'd4);
      check("t4_cnt0", 64'(burst_cnt0), 64'd8);

      // 5: random backpressure, source stalls and early tlast.
      rdy_mode  = 1'b1;
      stall_pct = 30;
      load(0, 600, 4, 1'b1);
      load(1, 600, 4, 1'b1);
      wait_drain("t5", 30000);
      check("t5_cnt0", 64'(burst_cnt0), 64'(bursts_m[0]));
      check("t5_cnt1", 64'(burst_cnt1), 64'(bursts_m[1]));
      rdy_mode  = 1'b0;
      stall_pct = 0;
      tick(2);

      // 6: asynchronous reset mid-burst; ch0 wins first afterwards.
      load(0, 100, 0, 1'b1);
      n = 0;
      while (beat_m < 40 && n < 1000) begin
         tick(1);
         n++;
      end
      check("t6_mid_reached", 64'(beat_m >= 40), 64'd1);
      #2 aresetn = 1'b0;
      #1;
      check("t6_rst_mvalid", 64'(m_tvalid), 64'd0);
      check("t6_rst_grant", 64'(grant), 64'd0);
      check("t6_rst_busy", 64'(busy), 64'd0);
      check("t6_rst_tready", 64'({s1_tready, s0_tready}), 64'd0);
      check("t6_rst_cnt0", 64'(burst_cnt0), 64'd0);
      check("t6_rst_cnt1", 64'(burst_cnt1), 64'd0);
      load(1, 50, 0, 1'b1);
      s = seq.size();
      tick(3);
      aresetn = 1'b1;
      wait_drain("t6", 1000);
      check_seq("t6_seq", s, 8'b10, 2);
      check("t6_cnt0", 64'(burst_cnt0), 64'd1);
      check("t6_cnt1", 64'(burst_cnt1), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
